// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin arbiter/sequencer sharing one alu_register among
// NUM_REQ requesters, one operation in flight, result returned over a
// valid/ready response channel tagged with the owning requester index.
// Build option: define ALU_ARB_FIXED_PRIO_EN to replace round-robin with
// fixed lowest-index-wins priority (no pointer register in that build).
module alu_arbiter #(
    parameter int unsigned WIDTH   = 8,
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned ALU_LAT = 1,
    parameter int unsigned IDW     = 2
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic [NUM_REQ-1:0]         req_valid_i,
    output logic [NUM_REQ-1:0]         req_ready_o,
    input  logic [NUM_REQ*WIDTH-1:0]   req_first_i,
    input  logic [NUM_REQ*WIDTH-1:0]   req_second_i,
    input  logic [NUM_REQ*3-1:0]       req_opcode_i,
    output logic [WIDTH-1:0]           alu_first_o,
    output logic [WIDTH-1:0]           alu_second_o,
    output logic [2:0]                 alu_opcode_o,
    input  logic [WIDTH-1:0]           alu_result_i,
    output logic                       resp_valid_o,
    input  logic                       resp_ready_i,
    output logic [WIDTH-1:0]           resp_data_o,
    output logic [IDW-1:0]             resp_id_o,
    output logic                       busy_o
);

    localparam int unsigned CNTW = (ALU_LAT > 1) ? $clog2(ALU_LAT + 1) : 1;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WAIT    = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_RESP    = 2'd3
    } state_t;

    state_t             r_state;
    logic [CNTW-1:0]    r_cnt;
    logic [WIDTH-1:0]   r_alu_first;
    logic [WIDTH-1:0]   r_alu_second;
    logic [2:0]         r_alu_opcode;
    logic               r_resp_valid;
    logic [WIDTH-1:0]   r_resp_data;
    logic [IDW-1:0]     r_resp_id;
    logic               r_busy;

    logic               w_found;
    logic [IDW-1:0]     w_gidx;
    logic [NUM_REQ-1:0] w_grant;
    logic               w_xfer;

`ifdef ALU_ARB_FIXED_PRIO_EN
    // Fixed priority: lowest-index valid requester wins.
    always_comb begin
        w_found = 1'b0;
        w_gidx  = '0;
        for (int i = 0; i < int'(NUM_REQ); i++) begin
            if (!w_found && req_valid_i[i]) begin
                w_found = 1'b1;
                w_gidx  = IDW'(i);
            end
        end
    end
`else
    logic [IDW-1:0] r_ptr;
    logic [IDW:0]   w_idx;

    // Round-robin: search from r_ptr+1 upward, wrapping modulo NUM_REQ.
    always_comb begin
        w_found = 1'b0;
        w_gidx  = '0;
        w_idx   = '0;
        for (int i = 0; i < int'(NUM_REQ); i++) begin
            w_idx = {1'b0, r_ptr} + (IDW+1)'(i + 1);
            if (w_idx >= (IDW+1)'(NUM_REQ)) begin
                w_idx = w_idx - (IDW+1)'(NUM_REQ);
            end
            if (!w_found && req_valid_i[w_idx[IDW-1:0]]) begin
                w_found = 1'b1;
                w_gidx  = w_idx[IDW-1:0];
            end
        end
    end
`endif

    // One-hot grant, offered only in IDLE and never while reset is held.
    always_comb begin
        w_grant = '0;
        if (w_found) begin
            w_grant = NUM_REQ'(1) << w_gidx;
        end
        req_ready_o = '0;
        if (rst_i && (r_state == ST_IDLE)) begin
            req_ready_o = w_grant;
        end
        w_xfer = rst_i && (r_state == ST_IDLE) && w_found;
    end

    // Sequencer FSM: grant, wait ALU latency, capture result, hold response.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            r_state      <= ST_IDLE;
            r_cnt        <= '0;
            r_alu_first  <= '0;
            r_alu_second <= '0;
            r_alu_opcode <= '0;
            r_resp_valid <= 1'b0;
            r_resp_data  <= '0;
            r_resp_id    <= '0;
            r_busy       <= 1'b0;
`ifndef ALU_ARB_FIXED_PRIO_EN
            r_ptr        <= IDW'(NUM_REQ - 1);
`endif
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_xfer) begin
                        r_alu_first  <= req_first_i[w_gidx*WIDTH +: WIDTH];
                        r_alu_second <= req_second_i[w_gidx*WIDTH +: WIDTH];
                        r_alu_opcode <= req_opcode_i[w_gidx*3 +: 3];
                        r_resp_id    <= w_gidx;
                        r_cnt        <= CNTW'(ALU_LAT);
                        r_state      <= ST_WAIT;
                        r_busy       <= 1'b1;
`ifndef ALU_ARB_FIXED_PRIO_EN
                        r_ptr        <= w_gidx;
`endif
                    end
                end
                ST_WAIT: begin
                    if (r_cnt <= CNTW'(1)) begin
                        r_state <= ST_CAPTURE;
                    end else begin
                        r_cnt <= r_cnt - CNTW'(1);
                    end
                end
                ST_CAPTURE: begin
                    r_resp_data  <= alu_result_i;
                    r_resp_valid <= 1'b1;
                    r_state      <= ST_RESP;
                end
                ST_RESP: begin
                    if (resp_ready_i) begin
                        r_resp_valid <= 1'b0;
                        r_busy       <= 1'b0;
                        r_state      <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign alu_first_o  = r_alu_first;
    assign alu_second_o = r_alu_second;
    assign alu_opcode_o = r_alu_opcode;
    assign resp_valid_o = r_resp_valid;
    assign resp_data_o  = r_resp_data;
    assign resp_id_o    = r_resp_id;
    assign busy_o       = r_busy;

endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
Round-robin arbiter and sequencer that shares one alu_register instance among NUM_REQ requesters. It grants one requester at a time and drives the ALU operand and opcode inputs from registered copies. It waits the ALU pipeline latency, captures the result, and returns it tagged with the requester index over a valid/ready response channel. Only one operation is outstanding at a time.

Parameters:
WIDTH, 8, operand/result width; must match the shared alu_register.
NUM_REQ, 4, number of requesters, 2..16.
ALU_LAT, 1, clock cycles from operands stable at the ALU inputs to result valid on alu_result_i, 1..4.
IDW, 2, requester index width, equal to clog2(NUM_REQ).

Ports:
clk_i  in  1  clock, rising edge.
rst_i  in  1  synchronous active-low reset.
req_valid_i  in  NUM_REQ  per-requester request valid.
req_ready_o  out  NUM_REQ  per-requester grant/accept, one-hot or zero.
req_first_i  in  NUM_REQ*WIDTH  flattened first operands; requester k occupies bits [k*WIDTH +: WIDTH].
req_second_i  in  NUM_REQ*WIDTH  flattened second operands, same packing.
req_opcode_i  in  NUM_REQ*3  flattened opcodes, 3 bits per requester.
alu_first_o  out  WIDTH  to ALU first_i.
alu_second_o  out  WIDTH  to ALU second_i.
alu_opcode_o  out  3  to ALU opcode_i.
alu_result_i  in  WIDTH  from ALU result_o.
resp_valid_o  out  1  response valid.
resp_ready_i  in  1  response consumer ready.
resp_data_o  out  WIDTH  captured ALU result.
resp_id_o  out  IDW  index of the requester that owns the response.
busy_o  out  1  high in any state other than IDLE.

Behaviour:
Reset (rst_i low at a clock edge), mid-operation included:
- State goes to IDLE and the wait counter clears.
- alu_first_o, alu_second_o and alu_opcode_o clear to 0.
- resp_valid_o, resp_data_o and resp_id_o clear to 0.
- The round-robin pointer is set to NUM_REQ-1, so requester 0 wins first.
- Any in-flight operation is dropped and no response is produced for it.
- req_ready_o is 0 while rst_i is low.

State machine (IDLE, WAIT, CAPTURE, RESP):
- IDLE: req_ready_o is combinational and equals a one-hot grant to the first valid requester, searching from pointer+1 upward and wrapping modulo NUM_REQ. req_ready_o is 0 in every other state.
- Handshake: a transfer occurs when req_valid_i[k] and req_ready_o[k] are both high.
- On a transfer: latch requester k's operands and opcode into the alu_* registers, latch k into resp_id_o, set pointer to k, load the wait counter with ALU_LAT, go to WAIT.
- WAIT: alu_* outputs hold. Decrement the counter each cycle; when it reaches 1, go to CAPTURE.
- CAPTURE: alu_result_i is sampled into resp_data_o at the end of this cycle; go to RESP.
- RESP: resp_valid_o is high. resp_data_o and resp_id_o hold until resp_valid_o and resp_ready_i are both high; then go to IDLE.
- There is no grant in the same cycle as response acceptance. Next-grant earliest cycle is the one after acceptance.

Timing and latency:
- From the handshake cycle T, resp_valid_o first rises in cycle T+ALU_LAT+2.
- Minimum issue interval is ALU_LAT+3 cycles.

Boundary rules:
- req_valid_i without ready is held by the requester. The arbiter needs no stability guarantee outside the grant cycle and only samples the granted requester's fields.
- Pointer wrap: after granting NUM_REQ-1, the search starts at 0.
- A single requester with all others idle is granted every opportunity.
- Backpressure: resp_ready_i low holds RESP indefinitely, with no grants.
- alu_* outputs retain the last issued operation after completion; they are not cleared.

Optional Feature:
Macro ALU_ARB_FIXED_PRIO_EN.
- Defined: the grant goes to the lowest-index valid requester every time. The pointer register is removed, and the stored pointer has no effect.
- Not defined: round-robin arbitration as specified above.
- All other behaviour, latency and reset values are identical in both builds.

Test Plan:
- Reset: hold rst_i low 2 cycles with all req_valid_i high -> req_ready_o=0, resp_valid_o=0, busy_o=0, alu_* outputs=0. First grant after release goes to requester 0.
- Single op, shared alu_register (ALU_LAT=1): requester 2 sends opcode 3'b010, first 8'h12, second 8'h34 at cycle T -> resp_valid_o at T+3, resp_data_o=8'h46, resp_id_o=2.
- Add wrap: requester 1 sends 3'b010, first 8'hFF, second 8'h01 -> resp_data_o=8'h00, resp_id_o=1.
- Round-robin: all 4 requesters valid continuously, resp_ready_i=1 -> grant order 0,1,2,3,0. The macro-defined build gives 0,0,0 instead.
- Backpressure: resp_ready_i held 0 for 5 cycles in RESP, with requester 3 valid -> resp_data_o and resp_id_o stable, req_ready_o=0. Raise resp_ready_i -> requester 3 is granted the following cycle.
- Reset mid-operation: assert rst_i in WAIT -> next cycle busy_o=0, no resp_valid_o is ever produced for that op, and the pointer is back to NUM_REQ-1.
